// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame width and default bit rate.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with clear; flags the terminal and half-period counts.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic terminal,
    output logic half
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] TermCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

    logic [CntW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear || terminal) begin
            count <= '0;
        end else begin
            count <= count + CntW'(1);
        end
    end

    assign terminal = (count == TermCnt);
    assign half     = (count == HalfCnt);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ack holding register, framing and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      serial_in,
    input  logic                      data_ack,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    output logic                      busy,
    output logic                      frame_error,
    output logic                      overrun
);

    localparam logic [2:0] LastBit = 3'(UART_DATA_BITS - 1);

    uart_state_e               state;
    logic                      rin;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      bit_tc;
    logic                      bit_half;
    logic                      timer_clear;

    // Idle pins the counter at zero so the start-bit half period is measured from E0.
    assign timer_clear = (state == StIdle) || ((state == StStart) && bit_half);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .terminal(bit_tc),
        .half    (bit_half)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            rin         <= 1'b1;
            bit_idx     <= '0;
            shift       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            rin         <= serial_in;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            // A delivery in the same cycle overrides this clear below.
            if (data_ack && data_valid) begin
                data_valid <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (!rin) state <= StStart;
                end
                StStart: begin
                    bit_idx <= '0;
                    if (bit_half) state <= rin ? StIdle : StData;
                end
                StData: begin
                    if (bit_tc) begin
                        shift[bit_idx] <= rin;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == LastBit) state <= StStop;
                    end
                end
                StStop: begin
                    if (bit_tc) begin
                        if (rin) begin
                            state <= StIdle;
                            if (!data_valid || data_ack) begin
                                data_out   <= shift;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            state       <= StWaitHigh;
                        end
                    end
                end
                StWaitHigh: begin
                    if (rin) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int unsigned Cpb = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_error;
    logic       overrun;

    int n_cmp = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vlow_cnt = 0;
    int fe0, ov0, vl0;

    uart_rx #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_error) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (!data_valid) vlow_cnt <= vlow_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit plus the first nbits data bits, LSB first.
    task automatic send_head(input logic [7:0] d, input int nbits);
        serial_in = 1'b0;
        wait_cycles(Cpb);
        for (int i = 0; i < nbits; i++) begin
            serial_in = d[i];
            wait_cycles(Cpb);
        end
    endtask

    // Returns one cycle after the stop-sample edge; 6 cycles of stop bit remain.
    task automatic send_frame(input logic [7:0] d);
        send_head(d, 8);
        serial_in = 1'b1;
        wait_cycles(10);
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        wait_cycles(1);
        data_ack = 1'b0;
    endtask

    initial begin
        // Reset values
        wait_cycles(3);
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fe", 32'(frame_error), 0);
        chk("rst_ov", 32'(overrun), 0);
        reset = 1'b0;
        wait_cycles(4);

        // 0xA5, cycle-exact delivery
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_head(8'hA5, 8);
        serial_in = 1'b1;
        chk("a5_busy_mid", 32'(busy), 1);
        wait_cycles(9);
        chk("a5_valid_early", 32'(data_valid), 0);
        wait_cycles(1);
        chk("a5_valid", 32'(data_valid), 1);
        chk("a5_data", 32'(data_out), 32'hA5);
        wait_cycles(7);
        chk("a5_busy_idle", 32'(busy), 0);
        chk("a5_fe_cnt", 32'(fe_cnt - fe0), 0);
        chk("a5_ov_cnt", 32'(ov_cnt - ov0), 0);
        ack_pulse();
        chk("a5_ack_valid", 32'(data_valid), 0);
        chk("a5_ack_hold", 32'(data_out), 32'hA5);

        // 3-cycle glitch: back to IDLE at E0+8
        wait_cycles(2);
        serial_in = 1'b0;
        wait_cycles(3);
        serial_in = 1'b1;
        wait_cycles(6);
        chk("glitch_busy_hi", 32'(busy), 1);
        wait_cycles(1);
        chk("glitch_busy_lo", 32'(busy), 0);
        chk("glitch_valid", 32'(data_valid), 0);
        wait_cycles(Cpb);

        // 0x3C with stop held low for 40 bit-times
        fe0 = fe_cnt;
        send_head(8'h3C, 8);
        wait_cycles(10);
        chk("fe_pulse", 32'(frame_error), 1);
        wait_cycles(1);
        chk("fe_pulse_end", 32'(frame_error), 0);
        chk("fe_busy_wait", 32'(busy), 1);
        wait_cycles(40 * Cpb - 11);
        serial_in = 1'b1;
        wait_cycles(2 * Cpb);
        chk("fe_count", 32'(fe_cnt - fe0), 1);
        chk("fe_valid", 32'(data_valid), 0);
        chk("fe_busy_lo", 32'(busy), 0);
        send_frame(8'h81);
        chk("after_fe_data", 32'(data_out), 32'h81);
        chk("after_fe_valid", 32'(data_valid), 1);
        wait_cycles(6);
        ack_pulse();

        // Overrun: 0x11 then 0x22, no ack
        ov0 = ov_cnt;
        send_frame(8'h11);
        chk("ov_first_data", 32'(data_out), 32'h11);
        chk("ov_first_pulse", 32'(overrun), 0);
        wait_cycles(6);
        send_frame(8'h22);
        chk("ov_pulse", 32'(overrun), 1);
        chk("ov_keep_data", 32'(data_out), 32'h11);
        wait_cycles(6);
        chk("ov_count", 32'(ov_cnt - ov0), 1);

        // Ack coincident with the stop-sample edge
        ov0 = ov_cnt;
        vl0 = vlow_cnt;
        send_head(8'h22, 8);
        serial_in = 1'b1;
        wait_cycles(9);
        data_ack = 1'b1;
        wait_cycles(1);
        data_ack = 1'b0;
        chk("coll_data", 32'(data_out), 32'h22);
        chk("coll_valid", 32'(data_valid), 1);
        chk("coll_ov", 32'(overrun), 0);
        wait_cycles(6);
        chk("coll_no_gap", 32'(vlow_cnt - vl0), 0);
        chk("coll_ov_count", 32'(ov_cnt - ov0), 0);

        // Reset during data bit 4
        send_head(8'hC3, 4);
        serial_in = 1'b0;
        wait_cycles(8);
        chk("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        serial_in = 1'b1;
        wait_cycles(1);
        chk("mid_rst_data", 32'(data_out), 32'h00);
        chk("mid_rst_valid", 32'(data_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_fe", 32'(frame_error), 0);
        chk("mid_rst_ov", 32'(overrun), 0);
        reset = 1'b0;
        wait_cycles(2 * Cpb);
        send_frame(8'h5A);
        chk("post_rst_data", 32'(data_out), 32'h5A);
        chk("post_rst_valid", 32'(data_valid), 1);
        wait_cycles(6);
        ack_pulse();

        // Back-to-back 0xFF, 0x00 with no idle between frames
        send_frame(8'hFF);
        chk("b2b_ff_data", 32'(data_out), 32'hFF);
        chk("b2b_ff_valid", 32'(data_valid), 1);
        ack_pulse();
        chk("b2b_ack_valid", 32'(data_valid), 0);
        wait_cycles(5);
        send_frame(8'h00);
        chk("b2b_00_data", 32'(data_out), 32'h00);
        chk("b2b_00_valid", 32'(data_valid), 1);
        chk("b2b_00_ov", 32'(overrun), 0);
        wait_cycles(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver fed by the buffered serial input line (`serial_buffer` output). It recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) at a fixed clocks-per-bit rate. Each received byte is presented to the processor-side logic through a one-entry holding register with a valid/ack handshake. Framing errors and overruns are flagged.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200); legal range 4..65535.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `serial_in`  in  1  buffered RX line; idle high.
- `data_ack`  in  1  consumer accepts `data_out` this cycle; ignored when `data_valid`=0.
- `data_out`  out  8  last received byte; reset 8'h00.
- `data_valid`  out  1  holding register full; reset 0.
- `busy`  out  1  FSM not in IDLE; reset 0.
- `frame_error`  out  1  one-cycle pulse on bad stop bit; reset 0.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped; reset 0.

One clock; reset is synchronous and active-high.

## Operation
- `serial_in` is registered once internally into `rin`, reset to 1. All sampling uses `rin`.
- HALF = floor(CLKS_PER_BIT/2). Bit counter is 0..CLKS_PER_BIT-1 with width clog2(CLKS_PER_BIT).
- FSM states:
  - IDLE: `rin`=0 → START, counter cleared.
  - START: at count HALF-1, if `rin`=0 → DATA (counter cleared, bit index 0). If `rin`=1 (glitch) → IDLE.
  - DATA: at count CLKS_PER_BIT-1, shift `rin` into bit[index]. After index 7 → STOP.
  - STOP: at count CLKS_PER_BIT-1, sample `rin`. If 1 → deliver, then IDLE. If 0 → pulse `frame_error`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rin`=1, then IDLE. A break condition produces exactly one `frame_error`.
- Deliver: if `data_valid`=0, or `data_ack`=1 in the same cycle, load `data_out` and set `data_valid`=1. Otherwise keep the old byte and pulse `overrun`.
- `data_ack` with `data_valid`=1 and no simultaneous deliver clears `data_valid` next edge; `data_out` holds its value.
- Reset mid-frame: the next edge puts the FSM in IDLE and all outputs at reset values; the partial byte is lost.

## Timing
- Edge E0 is the first edge at which the FSM in IDLE sees `rin`=0.
- Start is checked at E0+HALF. Data bit i (0..7) is sampled at E0+HALF+(i+1)·CLKS_PER_BIT. Stop is sampled at E0+HALF+9·CLKS_PER_BIT.
- `data_valid`, `frame_error` and `overrun` update at the stop-sample edge; they are visible the cycle after it.
- `busy` is high from E0+1 until the cycle after return to IDLE.
- Back-to-back frames: a start edge arriving one cycle after the stop sample must be caught. IDLE accepts a start on its first cycle.
- The ack-and-deliver collision yields no overrun and no gap in `data_valid`.

## Structure
- Package `uart_pkg`:
  - state encoding (IDLE, START, DATA, STOP, WAIT_HIGH);
  - `UART_DATA_BITS`=8;
  - default `CLKS_PER_BIT`.
- Sub-module `uart_bit_timer`: counter with clear, terminal-count and half-count outputs, parameterised by `CLKS_PER_BIT`. It is shared with the future `uart_tx`.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Frame 0xA5 with a good stop → `data_out`=8'hA5 and `data_valid`=1 at E0+HALF+9·16+1; no error pulses.
- 3-cycle low glitch on an idle line → FSM returns to IDLE at E0+8; no `data_valid`; `busy` drops.
- Frame 0x3C with the stop bit held low for 40 bit-times, then high → exactly one `frame_error` pulse; `data_valid` stays 0; next frame 0x81 is received correctly.
- Frames 0x11 then 0x22 with no `data_ack` → `data_out` stays 0x11; one `overrun` pulse at the second stop sample. Repeat with `data_ack` asserted exactly at the second stop-sample cycle → `data_out`=0x22, `data_valid` continuously 1, no `overrun`.
- Reset asserted one cycle during data bit 4 of a frame → all outputs at reset values on the next edge; the following clean frame 0x5A is received.
- Two frames 0xFF and 0x00 back-to-back with zero idle between them → both delivered in order with `data_ack` pulsed between them.
